// File: rtl/bomb_controller.sv
// Single-bomb placement, fuse timing, tile-by-tile blast scan and
// map clearing for the player downstream of player_controller.
module bomb_controller #(
  parameter int NUM_ROW       = 11,
  parameter int NUM_COL       = 19,
  parameter int TILE_PX       = 64,
  parameter int MAP_MEM_WIDTH = 2,
  parameter int SPRITE_W      = 32,
  parameter int SPRITE_H      = 48,
  parameter int FUSE_TICKS    = 180,
  parameter int EXPL_TICKS    = 30,
  parameter int BLAST_RANGE   = 2,
  localparam int ADDR_WIDTH   = $clog2(NUM_ROW*NUM_COL),
  localparam int LW           = $clog2(BLAST_RANGE+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     place_req,
  input  logic [10:0]              map_player_x,
  input  logic [9:0]               map_player_y,
  output logic [ADDR_WIDTH-1:0]    map_rd_addr,
  input  logic [MAP_MEM_WIDTH-1:0] map_rd_data,
  output logic                     map_we,
  output logic [ADDR_WIDTH-1:0]    map_wr_addr,
  output logic [MAP_MEM_WIDTH-1:0] map_wr_data,
  output logic                     bomb_active,
  output logic [3:0]               bomb_row,
  output logic [4:0]               bomb_col,
  output logic                     explode_pulse,
  output logic                     blast_active,
  output logic [LW-1:0]            blast_up,
  output logic [LW-1:0]            blast_down,
  output logic [LW-1:0]            blast_left,
  output logic [LW-1:0]            blast_right
);

  localparam int TSH  = $clog2(TILE_PX);
  localparam int AW1  = ADDR_WIDTH + 1;
  localparam int CMAX = (FUSE_TICKS > EXPL_TICKS) ? FUSE_TICKS : EXPL_TICKS;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRD   = 3'd1;
  localparam logic [2:0] S_PCHK  = 3'd2;
  localparam logic [2:0] S_ARMED = 3'd3;
  localparam logic [2:0] S_SRD   = 3'd4;
  localparam logic [2:0] S_SCHK  = 3'd5;
  localparam logic [2:0] S_CLEAR = 3'd6;
  localparam logic [2:0] S_BLAST = 3'd7;

  localparam logic [1:0] D_UP = 2'd0;
  localparam logic [1:0] D_DN = 2'd1;
  localparam logic [1:0] D_LF = 2'd2;
  localparam logic [1:0] D_RT = 2'd3;

  localparam logic [MAP_MEM_WIDTH-1:0] M_FREE  = MAP_MEM_WIDTH'(0);
  localparam logic [MAP_MEM_WIDTH-1:0] M_DESTR = MAP_MEM_WIDTH'(1);
  localparam logic [MAP_MEM_WIDTH-1:0] M_BOMB  = MAP_MEM_WIDTH'(3);

  logic [2:0]    state_q, state_d;
  logic [3:0]    row_q, row_d;
  logic [4:0]    col_q, col_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dir_q, dir_d;
  logic [LW-1:0] dist_q, dist_d;
  logic [LW-1:0] up_q, up_d, dn_q, dn_d;
  logic [LW-1:0] lf_q, lf_d, rt_q, rt_d;

  logic [11:0] cx;
  logic [10:0] cy;
  logic [3:0]  tgt_row;
  logic [4:0]  tgt_col;

  // sprite centre, kept wide so the carry survives the shift
  assign cx      = {1'b0, map_player_x} + 12'(SPRITE_W/2);
  assign cy      = {1'b0, map_player_y} + 11'(SPRITE_H/2);
  assign tgt_col = 5'(cx >> TSH);
  assign tgt_row = 4'(cy >> TSH);

  function automatic logic [AW1-1:0] tile_addr(
    input logic [7:0] r,
    input logic [7:0] c
  );
    return AW1'(r) * AW1'(NUM_COL) + AW1'(c);
  endfunction

  logic [7:0] r8, c8, d8, srow, scol;
  logic       oob;
  logic [ADDR_WIDTH-1:0] bomb_addr, scan_addr;

  always_comb begin
    r8   = 8'(row_q);
    c8   = 8'(col_q);
    d8   = 8'(dist_q);
    srow = r8;
    scol = c8;
    oob  = 1'b0;
    unique case (dir_q)
      D_UP: begin
        oob  = d8 > r8;
        srow = r8 - d8;
      end
      D_DN: begin
        oob  = (r8 + d8) > 8'(NUM_ROW-1);
        srow = r8 + d8;
      end
      D_LF: begin
        oob  = d8 > c8;
        scol = c8 - d8;
      end
      default: begin
        oob  = (c8 + d8) > 8'(NUM_COL-1);
        scol = c8 + d8;
      end
    endcase
  end

  assign bomb_addr = ADDR_WIDTH'(tile_addr(8'(row_q), 8'(col_q)));
  assign scan_addr = ADDR_WIDTH'(tile_addr(srow, scol));

  logic [ADDR_WIDTH-1:0]    rd_addr, wr_addr;
  logic [MAP_MEM_WIDTH-1:0] wr_data;
  logic                     we, pulse, len_we, adv;
  logic [LW-1:0]            len_val;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    dist_d  = dist_q;
    up_d    = up_q;
    dn_d    = dn_q;
    lf_d    = lf_q;
    rt_d    = rt_q;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    we      = 1'b0;
    pulse   = 1'b0;
    len_we  = 1'b0;
    len_val = '0;
    adv     = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (place_req) begin
          row_d   = tgt_row;
          col_d   = tgt_col;
          state_d = S_PRD;
        end
      end
      (state_q == S_PRD): begin
        rd_addr = bomb_addr;
        state_d = S_PCHK;
      end
      (state_q == S_PCHK): begin
        if (map_rd_data == M_FREE) begin
          we      = 1'b1;
          wr_addr = bomb_addr;
          wr_data = M_BOMB;
          cnt_d   = CW'(FUSE_TICKS);
          state_d = S_ARMED;
        end else begin
          state_d = S_IDLE;
        end
      end
      (state_q == S_ARMED): begin
        if (tick) begin
          if (cnt_q <= CW'(1)) begin
            cnt_d   = '0;
            dir_d   = D_UP;
            dist_d  = LW'(1);
            up_d    = '0;
            dn_d    = '0;
            lf_d    = '0;
            rt_d    = '0;
            state_d = S_SRD;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      (state_q == S_SRD): begin
        if (oob) begin
          len_we  = 1'b1;
          len_val = dist_q - LW'(1);
          adv     = 1'b1;
        end else begin
          rd_addr = scan_addr;
          state_d = S_SCHK;
        end
      end
      (state_q == S_SCHK): begin
        len_we = 1'b1;
        if (map_rd_data == M_FREE) begin
          len_val = dist_q;
          if (dist_q < LW'(BLAST_RANGE)) begin
            dist_d  = dist_q + LW'(1);
            state_d = S_SRD;
          end else begin
            adv = 1'b1;
          end
        end else if (map_rd_data == M_DESTR) begin
          we      = 1'b1;
          wr_addr = scan_addr;
          wr_data = M_FREE;
          len_val = dist_q;
          adv     = 1'b1;
        end else begin
          len_val = dist_q - LW'(1);
          adv     = 1'b1;
        end
      end
      (state_q == S_CLEAR): begin
        we      = 1'b1;
        wr_addr = bomb_addr;
        wr_data = M_FREE;
        pulse   = 1'b1;
        cnt_d   = CW'(EXPL_TICKS);
        state_d = S_BLAST;
      end
      (state_q == S_BLAST): begin
        if (tick) begin
          if (cnt_q <= CW'(1)) begin
            cnt_d   = '0;
            up_d    = '0;
            dn_d    = '0;
            lf_d    = '0;
            rt_d    = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (len_we) begin
      unique case (dir_q)
        D_UP:    up_d = len_val;
        D_DN:    dn_d = len_val;
        D_LF:    lf_d = len_val;
        default: rt_d = len_val;
      endcase
    end
    // arm finished: move to the next direction, RIGHT being last
    if (adv) begin
      dist_d = LW'(1);
      if (dir_q == D_RT) begin
        state_d = S_CLEAR;
      end else begin
        dir_d   = dir_q + 2'd1;
        state_d = S_SRD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= '0;
      dist_q  <= '0;
      up_q    <= '0;
      dn_q    <= '0;
      lf_q    <= '0;
      rt_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      dist_q  <= dist_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      lf_q    <= lf_d;
      rt_q    <= rt_d;
    end
  end

  assign map_rd_addr   = rd_addr;
  assign map_we        = we;
  assign map_wr_addr   = wr_addr;
  assign map_wr_data   = wr_data;
  assign explode_pulse = pulse;
  assign bomb_active   = (state_q == S_ARMED);
  assign blast_active  = (state_q == S_BLAST);
  assign bomb_row      = row_q;
  assign bomb_col      = col_q;
  assign blast_up      = up_q;
  assign blast_down    = dn_q;
  assign blast_left    = lf_q;
  assign blast_right   = rt_q;

endmodule

// File: tb/tb_bomb_controller.sv
// Scoreboard bench for bomb_controller: map memory model, reference
// model of placement/blast, and an output monitor.
module tb_bomb_controller;

  localparam int NR    = 11;
  localparam int NC    = 19;
  localparam int FUSE  = 4;
  localparam int EXPL  = 3;
  localparam int RANGE = 2;
  localparam int NT    = NR * NC;
  localparam int AW    = $clog2(NT);
  localparam int LW    = $clog2(RANGE + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic          place_req;
  logic [10:0]   px;
  logic [9:0]    py;
  logic [AW-1:0] map_rd_addr;
  logic [1:0]    map_rd_data;
  logic          map_we;
  logic [AW-1:0] map_wr_addr;
  logic [1:0]    map_wr_data;
  logic          bomb_active;
  logic [3:0]    bomb_row;
  logic [4:0]    bomb_col;
  logic          explode_pulse;
  logic          blast_active;
  logic [LW-1:0] blast_up, blast_down, blast_left, blast_right;

  bomb_controller #(
    .NUM_ROW(NR), .NUM_COL(NC), .TILE_PX(64), .MAP_MEM_WIDTH(2),
    .SPRITE_W(32), .SPRITE_H(48), .FUSE_TICKS(FUSE),
    .EXPL_TICKS(EXPL), .BLAST_RANGE(RANGE)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .place_req(place_req),
    .map_player_x(px), .map_player_y(py),
    .map_rd_addr(map_rd_addr), .map_rd_data(map_rd_data),
    .map_we(map_we), .map_wr_addr(map_wr_addr),
    .map_wr_data(map_wr_data), .bomb_active(bomb_active),
    .bomb_row(bomb_row), .bomb_col(bomb_col),
    .explode_pulse(explode_pulse), .blast_active(blast_active),
    .blast_up(blast_up), .blast_down(blast_down),
    .blast_left(blast_left), .blast_right(blast_right)
  );

  always #5 clk = ~clk;

  // map memory: synchronous read, one-cycle latency
  logic [1:0] mem [NT];
  logic [1:0] init_map [NT];
  logic       init_req = 1'b0;

  always @(posedge clk) begin
    if (init_req) mem <= init_map;
    else if (map_we) mem[map_wr_addr] <= map_wr_data;
    map_rd_data <= mem[map_rd_addr];
  end

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int row; int col; } bomb_t;
  typedef struct { int up; int dn; int lf; int rt; } blast_t;

  wr_t    exp_wr[$];
  bomb_t  exp_bomb[$];
  blast_t exp_blast[$];
  int     rmap[NT];
  int     checks = 0;
  int     failures = 0;
  int     pulses = 0;
  int     last_col = -1;
  bit     tick_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // reference model: whole bomb lifecycle from the map rules
  task automatic predict(input int x, input int y, output bit ok);
    int row, col, a;
    int len[4];
    int dr[4] = '{-1, 1, 0, 0};
    int dc[4] = '{0, 0, -1, 1};
    row = (y + 24) / 64;
    col = (x + 16) / 64;
    a   = row * NC + col;
    ok  = (rmap[a] == 0);
    if (!ok) return;
    exp_wr.push_back(wr_t'{a, 3});
    exp_bomb.push_back(bomb_t'{row, col});
    rmap[a] = 3;
    for (int k = 0; k < 4; k++) begin
      len[k] = 0;
      for (int s = 1; s <= RANGE; s++) begin
        int r = row + dr[k] * s;
        int c = col + dc[k] * s;
        int t;
        if (r < 0 || r >= NR || c < 0 || c >= NC) break;
        t = rmap[r * NC + c];
        if (t == 0) begin
          len[k] = s;
          continue;
        end
        if (t == 1) begin
          len[k] = s;
          rmap[r * NC + c] = 0;
          exp_wr.push_back(wr_t'{r * NC + c, 0});
        end
        break;
      end
    end
    exp_wr.push_back(wr_t'{a, 0});
    rmap[a] = 0;
    exp_blast.push_back(blast_t'{len[0], len[1], len[2], len[3]});
  endtask

  initial begin : monitor
    logic   ba_prev;
    wr_t    w;
    bomb_t  b;
    blast_t x;
    ba_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (map_we) begin
        if (exp_wr.size() == 0) begin
          chk("wr_unexpected", int'(map_wr_addr), -1);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr", int'(map_wr_addr), w.addr);
          chk("wr_data", int'(map_wr_data), w.data);
        end
      end
      if (explode_pulse) begin
        pulses++;
        if (exp_blast.size() == 0) begin
          chk("blast_unexpected", int'(explode_pulse), 0);
        end else begin
          x = exp_blast.pop_front();
          chk("len_up", int'(blast_up), x.up);
          chk("len_down", int'(blast_down), x.dn);
          chk("len_left", int'(blast_left), x.lf);
          chk("len_right", int'(blast_right), x.rt);
        end
      end
      if (bomb_active && !ba_prev) begin
        last_col = int'(bomb_col);
        if (exp_bomb.size() == 0) begin
          chk("bomb_unexpected", int'(bomb_active), 0);
        end else begin
          b = exp_bomb.pop_front();
          chk("bomb_row", int'(bomb_row), b.row);
          chk("bomb_col", int'(bomb_col), b.col);
        end
      end
      ba_prev = bomb_active;
    end
  end

  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tick = tick_en && ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic sel(input int k);
    return (k == 0) ? bomb_active : blast_active;
  endfunction

  task automatic wait_sig(input int k, input logic v, input int budget,
                          input string nm);
    int n = 0;
    while (sel(k) !== v && n < budget) begin
      step(1);
      n++;
    end
    chk(nm, int'(sel(k)), int'(v));
  endtask

  task automatic lifecycle(input string nm);
    wait_sig(0, 1'b1, 20, {nm, "_armed"});
    wait_sig(0, 1'b0, 400, {nm, "_fuse"});
    wait_sig(1, 1'b1, 60, {nm, "_blast_on"});
    wait_sig(1, 1'b0, 400, {nm, "_blast_off"});
  endtask

  task automatic load_map();
    for (int i = 0; i < NT; i++) init_map[i] = 2'(rmap[i]);
    init_req = 1'b1;
    step(1);
    init_req = 1'b0;
  endtask

  task automatic border_map();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        rmap[r * NC + c] =
          (r == 0 || r == NR-1 || c == 0 || c == NC-1) ? 2 : 0;
  endtask

  task automatic run_place(input int x, input int y, input string nm);
    bit ok;
    predict(x, y, ok);
    px = 11'(x);
    py = 10'(y);
    place_req = 1'b1;
    step(1);
    place_req = 1'b0;
    if (!ok) begin
      step(2);
      chk({nm, "_nobomb"}, int'(bomb_active), 0);
    end else begin
      lifecycle(nm);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rd_addr"}, int'(map_rd_addr), 0);
    chk({nm, "_we"}, int'(map_we), 0);
    chk({nm, "_wr_addr"}, int'(map_wr_addr), 0);
    chk({nm, "_wr_data"}, int'(map_wr_data), 0);
    chk({nm, "_bomb"}, int'(bomb_active), 0);
    chk({nm, "_row"}, int'(bomb_row), 0);
    chk({nm, "_col"}, int'(bomb_col), 0);
    chk({nm, "_pulse"}, int'(explode_pulse), 0);
    chk({nm, "_blast"}, int'(blast_active), 0);
    chk({nm, "_lens"}, int'(blast_up) + int'(blast_down)
        + int'(blast_left) + int'(blast_right), 0);
  endtask

  initial begin : driver
    bit ok, ok2;
    int p0, n, r, c, v;
    rst = 1'b0;
    place_req = 1'b0;
    px = '0;
    py = '0;
    for (int i = 0; i < NT; i++) rmap[i] = 0;
    load_map();
    step(2);
    chk_zero("reset");
    rst = 1'b1;
    step(1);

    // placement timing and blast geometry at (1,1)
    border_map();
    rmap[1 * NC + 2] = 1;
    load_map();
    predict(64, 64, ok);
    px = 11'd64;
    py = 10'd64;
    place_req = 1'b1;
    step(1);
    place_req = 1'b0;
    chk("latch_row", int'(bomb_row), 1);
    chk("latch_col", int'(bomb_col), 1);
    chk("place_rd_addr", int'(map_rd_addr), 20);
    step(1);
    chk("place_we", int'(map_we), 1);
    chk("place_wr_addr", int'(map_wr_addr), 20);
    chk("place_wr_data", int'(map_wr_data), 3);
    chk("place_bomb_early", int'(bomb_active), 0);
    step(1);
    chk("place_bomb_on", int'(bomb_active), 1);
    tick_en = 1'b1;
    p0 = pulses;
    wait_sig(0, 1'b0, 400, "d1_fuse");
    wait_sig(1, 1'b1, 60, "d1_blast_on");
    chk("d1_up", int'(blast_up), 0);
    chk("d1_down", int'(blast_down), 2);
    chk("d1_left", int'(blast_left), 0);
    chk("d1_right", int'(blast_right), 1);
    wait_sig(1, 1'b0, 400, "d1_blast_off");
    chk("d1_pulses", pulses - p0, 1);
    chk("d1_mem21", int'(mem[21]), 0);
    chk("d1_mem20", int'(mem[20]), 0);

    // target holds a destructible block
    rmap[5 * NC + 5] = 1;
    load_map();
    run_place(320, 320, "destr");
    chk("destr_kept", int'(mem[5 * NC + 5]), 1);

    // centre lands exactly on a tile boundary
    run_place(48, 64, "colb");
    chk("col_boundary", last_col, 1);

    // held request: ignored while busy, honoured right after blast
    predict(64, 64, ok);
    predict(64, 64, ok2);
    px = 11'd64;
    py = 10'd64;
    place_req = 1'b1;
    step(1);
    lifecycle("held1");
    n = 0;
    while (!bomb_active && n < 10) begin
      step(1);
      n++;
    end
    chk("held_gap", n, 3);
    place_req = 1'b0;
    lifecycle("held2");

    // reset during the scan
    run_place(192, 192, "pre_rst");
    predict(192, 192, ok);
    px = 11'd192;
    py = 10'd192;
    place_req = 1'b1;
    step(1);
    place_req = 1'b0;
    wait_sig(0, 1'b1, 20, "rst_armed");
    wait_sig(0, 1'b0, 400, "rst_fuse");
    rst = 1'b0;
    exp_wr.delete();
    exp_bomb.delete();
    exp_blast.delete();
    step(1);
    chk_zero("rst_scan");
    step(3);
    rst = 1'b1;
    border_map();
    load_map();
    run_place(192, 192, "post_rst");

    // random maps and positions, including map edges
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < NT; i++) begin
        v = $urandom_range(0, 19);
        rmap[i] = (v < 10) ? 0 : (v < 15) ? 1 : (v < 19) ? 2 : 3;
      end
      load_map();
      r = $urandom_range(0, NR - 1);
      c = $urandom_range(0, NC - 1);
      run_place(c * 64 - 16 + $urandom_range(c == 0 ? 16 : 0, 63),
                r * 64 - 24 + $urandom_range(r == 0 ? 24 : 0, 63),
                "rand");
    end

    step(2);
    chk("left_writes", exp_wr.size(), 0);
    chk("left_bombs", exp_bomb.size(), 0);
    chk("left_blasts", exp_blast.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
